// File: rtl/fp_add_align_pkg.sv
// Shared constants and type codes for the single-precision adder alignment stage.
package fp_add_align_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 26;

    typedef enum logic [2:0] {
        TYPE_ZERO   = 3'd0,
        TYPE_DENORM = 3'd1,
        TYPE_NORMAL = 3'd2,
        TYPE_INF    = 3'd3,
        TYPE_NAN    = 3'd4
    } fp_type_e;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [31:0] inf_word(input logic sign);
        return {sign, 8'hFF, 23'h0};
    endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand-pair input and aligned-result output channels of the alignment stage.
interface fp_add_align_if
    import fp_add_align_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
);
    logic              in_valid;
    logic              in_ready;
    logic              op_sub;
    logic              a_sign;
    logic              b_sign;
    logic [EXP_W-1:0]  a_exp;
    logic [EXP_W-1:0]  b_exp;
    logic [MANT_W-1:0] a_mant;
    logic [MANT_W-1:0] b_mant;
    logic [2:0]        a_type;
    logic [2:0]        b_type;

    logic              out_valid;
    logic              out_ready;
    logic              res_sign;
    logic [EXP_W-1:0]  res_exp;
    logic              eff_sub;
    logic [MANT_W:0]   big_mant;
    logic [MANT_W:0]   small_mant;
    logic              special;
    logic [31:0]       special_word;

    modport master (
        output in_valid, op_sub, a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, a_type, b_type,
        output out_ready,
        input  in_ready,
        input  out_valid, res_sign, res_exp, eff_sub, big_mant, small_mant, special, special_word
    );

    modport slave (
        input  in_valid, op_sub, a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, a_type, b_type,
        input  out_ready,
        output in_ready,
        output out_valid, res_sign, res_exp, eff_sub, big_mant, small_mant, special, special_word
    );

endinterface

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift of {mant, 1'b0} by diff; bits shifted out are ORed into bit 0.
module fp_sticky_shifter #(
    parameter int MANT_W = 26,
    parameter int EXP_W  = 8
) (
    input  logic [MANT_W-1:0] mant_i,
    input  logic [EXP_W-1:0]  diff_i,
    output logic [MANT_W:0]   mant_o
);
    localparam int W = MANT_W + 1;

    logic [W-1:0] ext;
    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic [31:0]  diff32;
    logic         sticky;

    always_comb begin
        ext     = {mant_i, 1'b0};
        diff32  = 32'(diff_i);
        shifted = ext >> diff_i;
        for (int unsigned i = 0; i < W; i++) begin
            lost_mask[i] = (i < diff32);
        end
        sticky = |(ext & lost_mask);
        if (diff32 >= W) begin
            mant_o = {{MANT_W{1'b0}}, |mant_i};
        end else begin
            mant_o = {shifted[W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fp_add_align.sv
// Adder alignment stage: S1 compares/swaps and resolves specials, S2 shifts the small
// mantissa with sticky. Two-deep valid/ready pipeline with bubble collapsing.
module fp_add_align
    import fp_add_align_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input logic           clk,
    input logic           reset,
    fp_add_align_if.slave bus
);
    logic [EXP_W-1:0] a_eexp, b_eexp;
    logic             a_big, b_eff_sign, eff_sub_c;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             s1_special_d;
    logic [31:0]      s1_word_d;
    logic             s1_adv, s2_adv;
    logic [MANT_W:0]  shifted;

    logic              s1_valid_q, s1_sign_q, s1_eff_sub_q, s1_special_q;
    logic [EXP_W-1:0]  s1_exp_q, s1_diff_q;
    logic [MANT_W-1:0] s1_big_q, s1_small_q;
    logic [31:0]       s1_word_q;

    logic              out_valid_q, res_sign_q, eff_sub_q, special_q;
    logic [EXP_W-1:0]  res_exp_q;
    logic [MANT_W:0]   big_mant_q, small_mant_q;
    logic [31:0]       word_q;

    assign a_eexp     = (bus.a_type == TYPE_DENORM) ? EXP_W'(1) : bus.a_exp;
    assign b_eexp     = (bus.b_type == TYPE_DENORM) ? EXP_W'(1) : bus.b_exp;
    assign a_big      = {a_eexp, bus.a_mant} >= {b_eexp, bus.b_mant};
    assign b_eff_sign = bus.b_sign ^ bus.op_sub;
    assign eff_sub_c  = bus.a_sign ^ b_eff_sign;

    assign a_nan  = (bus.a_type == TYPE_NAN);
    assign b_nan  = (bus.b_type == TYPE_NAN);
    assign a_inf  = (bus.a_type == TYPE_INF);
    assign b_inf  = (bus.b_type == TYPE_INF);
    assign a_zero = (bus.a_type == TYPE_ZERO);
    assign b_zero = (bus.b_type == TYPE_ZERO);

    // Special-case priority: NaN, Inf-Inf, single Inf, signed zero.
    always_comb begin
        s1_special_d = 1'b1;
        s1_word_d    = QNAN;
        if (a_nan || b_nan) begin
            s1_word_d = QNAN;
        end else if (a_inf && b_inf && eff_sub_c) begin
            s1_word_d = QNAN;
        end else if (a_inf) begin
            s1_word_d = inf_word(bus.a_sign);
        end else if (b_inf) begin
            s1_word_d = inf_word(b_eff_sign);
        end else if (a_zero && b_zero) begin
            s1_word_d = {bus.a_sign & b_eff_sign, 31'h0};
        end else begin
            s1_special_d = 1'b0;
            s1_word_d    = '0;
        end
    end

    assign s2_adv = ~out_valid_q | bus.out_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_eff_sub_q <= 1'b0;
            s1_special_q <= 1'b0;
            s1_exp_q     <= '0;
            s1_diff_q    <= '0;
            s1_big_q     <= '0;
            s1_small_q   <= '0;
            s1_word_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q    <= a_big ? bus.a_sign : b_eff_sign;
                s1_exp_q     <= a_big ? a_eexp : b_eexp;
                s1_diff_q    <= a_big ? (a_eexp - b_eexp) : (b_eexp - a_eexp);
                s1_big_q     <= a_big ? bus.a_mant : bus.b_mant;
                s1_small_q   <= a_big ? bus.b_mant : bus.a_mant;
                s1_eff_sub_q <= eff_sub_c;
                s1_special_q <= s1_special_d;
                s1_word_q    <= s1_word_d;
            end
        end
    end

    fp_sticky_shifter #(
        .MANT_W(MANT_W),
        .EXP_W (EXP_W)
    ) u_shift (
        .mant_i(s1_small_q),
        .diff_i(s1_diff_q),
        .mant_o(shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            res_sign_q   <= 1'b0;
            eff_sub_q    <= 1'b0;
            special_q    <= 1'b0;
            res_exp_q    <= '0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            word_q       <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_sign_q   <= s1_sign_q;
                res_exp_q    <= s1_exp_q;
                eff_sub_q    <= s1_eff_sub_q;
                big_mant_q   <= {s1_big_q, 1'b0};
                small_mant_q <= shifted;
                special_q    <= s1_special_q;
                word_q       <= s1_word_q;
            end
        end
    end

    assign bus.in_ready     = s1_adv;
    assign bus.out_valid    = out_valid_q;
    assign bus.res_sign     = res_sign_q;
    assign bus.res_exp      = res_exp_q;
    assign bus.eff_sub      = eff_sub_q;
    assign bus.big_mant     = big_mant_q;
    assign bus.small_mant   = small_mant_q;
    assign bus.special      = special_q;
    assign bus.special_word = word_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed and randomised-stall bench for fp_add_align against a bit-serial reference model.
module tb_fp_add_align;
    import fp_add_align_pkg::*;

    typedef struct packed {
        logic        op;
        logic        as;
        logic [7:0]  ae;
        logic [25:0] am;
        logic [2:0]  at;
        logic        bs;
        logic [7:0]  be;
        logic [25:0] bm;
        logic [2:0]  bt;
    } pair_t;

    typedef struct packed {
        logic        r_sign;
        logic [7:0]  r_exp;
        logic        r_eff;
        logic [26:0] r_big;
        logic [26:0] r_small;
        logic        r_spec;
        logic [31:0] r_word;
    } res_t;

    localparam logic [25:0] ONE = 26'h2000000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp_add_align_if bus ();

    fp_add_align dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_res(input string tag, input res_t obs, input res_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pair_t mk(input logic op, input logic as, input logic [7:0] ae,
                                 input logic [25:0] am, input logic [2:0] at, input logic bs,
                                 input logic [7:0] be, input logic [25:0] bm, input logic [2:0] bt);
        pair_t p;
        p.op = op; p.as = as; p.ae = ae; p.am = am; p.at = at;
        p.bs = bs; p.be = be; p.bm = bm; p.bt = bt;
        return p;
    endfunction

    function automatic res_t mkres(input logic s, input logic [7:0] e, input logic eff,
                                   input logic [26:0] bg, input logic [26:0] sm);
        res_t r;
        r = '0;
        r.r_sign = s; r.r_exp = e; r.r_eff = eff; r.r_big = bg; r.r_small = sm;
        return r;
    endfunction

    task automatic drive(input pair_t p);
        bus.op_sub = p.op;
        bus.a_sign = p.as; bus.a_exp = p.ae; bus.a_mant = p.am; bus.a_type = p.at;
        bus.b_sign = p.bs; bus.b_exp = p.be; bus.b_mant = p.bm; bus.b_type = p.bt;
    endtask

    function automatic res_t observe();
        res_t r;
        r.r_sign  = bus.res_sign;
        r.r_exp   = bus.res_exp;
        r.r_eff   = bus.eff_sub;
        r.r_big   = bus.big_mant;
        r.r_small = bus.small_mant;
        r.r_spec  = bus.special;
        r.r_word  = bus.special_word;
        return r;
    endfunction

    function automatic res_t model(input pair_t p);
        res_t        r;
        logic [7:0]  ea, eb;
        logic [25:0] ms;
        logic [26:0] m;
        logic        abig, bsx, st;
        int          d;
        ea   = (p.at == TYPE_DENORM) ? 8'd1 : p.ae;
        eb   = (p.bt == TYPE_DENORM) ? 8'd1 : p.be;
        abig = (ea > eb) || ((ea == eb) && (p.am >= p.bm));
        bsx  = p.bs ^ p.op;
        r    = '0;
        r.r_eff = p.as ^ bsx;
        if (abig) begin
            r.r_sign = p.as; r.r_exp = ea; r.r_big = {p.am, 1'b0}; ms = p.bm; d = int'(ea) - int'(eb);
        end else begin
            r.r_sign = bsx; r.r_exp = eb; r.r_big = {p.bm, 1'b0}; ms = p.am; d = int'(eb) - int'(ea);
        end
        m  = {ms, 1'b0};
        st = 1'b0;
        for (int k = 0; k < d; k++) begin
            st = st | m[0];
            m  = m >> 1;
        end
        m[0] = m[0] | st;
        r.r_small = m;
        r.r_spec  = 1'b1;
        if (p.at == TYPE_NAN || p.bt == TYPE_NAN)                   r.r_word = 32'h7FC00000;
        else if (p.at == TYPE_INF && p.bt == TYPE_INF && r.r_eff)   r.r_word = 32'h7FC00000;
        else if (p.at == TYPE_INF)                                  r.r_word = {p.as, 8'hFF, 23'h0};
        else if (p.bt == TYPE_INF)                                  r.r_word = {bsx, 8'hFF, 23'h0};
        else if (p.at == TYPE_ZERO && p.bt == TYPE_ZERO)            r.r_word = {p.as & bsx, 31'h0};
        else begin
            r.r_spec = 1'b0;
            r.r_word = '0;
        end
        return r;
    endfunction

    task automatic rand_op(output logic s, output logic [7:0] e, output logic [25:0] m,
                           output logic [2:0] t);
        int sel;
        sel = int'($urandom_range(0, 19));
        s   = 1'($urandom_range(0, 1));
        if (sel == 0) begin
            t = TYPE_ZERO; e = 8'd0; m = '0;
        end else if (sel == 1) begin
            t = TYPE_DENORM; e = 8'd0; m = {1'b0, 23'($urandom), 2'b00};
        end else if (sel == 2) begin
            t = TYPE_INF; e = 8'hFF; m = '0;
        end else if (sel == 3) begin
            t = TYPE_NAN; e = 8'hFF; m = {1'b1, 23'h400000, 2'b00};
        end else begin
            t = TYPE_NORMAL;
            e = (sel < 7) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(110, 140));
            m = {1'b1, 23'($urandom), 2'b00};
        end
    endtask

    task automatic rand_pair(output pair_t p);
        logic        s;
        logic [7:0]  e;
        logic [25:0] m;
        logic [2:0]  t;
        p.op = 1'($urandom_range(0, 1));
        rand_op(s, e, m, t); p.as = s; p.ae = e; p.am = m; p.at = t;
        rand_op(s, e, m, t); p.bs = s; p.be = e; p.bm = m; p.bt = t;
    endtask

    task automatic send_single(input string tag, input pair_t p, output res_t r);
        drive(p);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
        r = observe();
        tick();
    endtask

    initial begin
        pair_t p0, p1, p2, p3, cur;
        res_t  r, e0, e1, e2, e3, ex;
        res_t  q[$];
        int    sent, recv;
        logic  holding;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive('0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_res("rst_data", observe(), '0);

        send_single("one_plus_one", mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd127, ONE, TYPE_NORMAL), r);
        check_res("one_plus_one", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h4000000));
        check("idle_after", 32'(bus.out_valid), 32'd0);

        send_single("one_plus_half", mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd126, ONE, TYPE_NORMAL), r);
        check_res("one_plus_half", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h2000000));
        send_single("half_plus_one", mk(0, 0, 8'd126, ONE, TYPE_NORMAL, 0, 8'd127, ONE, TYPE_NORMAL), r);
        check_res("half_plus_one", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h2000000));

        send_single("tiny", mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd87, ONE, TYPE_NORMAL), r);
        check_res("tiny_diff40", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h0000001));
        send_single("tie_sub", mk(1, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd127, ONE, TYPE_NORMAL), r);
        check_res("tie_sub", r, mkres(0, 8'd127, 1, 27'h4000000, 27'h4000000));
        send_single("sticky4", mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd123, 26'h2000004, TYPE_NORMAL), r);
        check_res("sticky_diff4", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h0400001));
        send_single("diff27", mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd100, 26'h2000004, TYPE_NORMAL), r);
        check_res("diff27", r, mkres(0, 8'd127, 0, 27'h4000000, 27'h0000001));
        send_single("denorm", mk(0, 0, 8'd1, ONE, TYPE_NORMAL, 0, 8'd0, 26'h0800000, TYPE_DENORM), r);
        check_res("denorm_eff_exp", r, mkres(0, 8'd1, 0, 27'h4000000, 27'h1000000));

        send_single("nan", mk(0, 0, 8'hFF, 26'h2400000, TYPE_NAN, 0, 8'd127, ONE, TYPE_NORMAL), r);
        check("nan_special", 32'(r.r_spec), 32'd1);
        check("nan_word", r.r_word, 32'h7FC00000);
        send_single("inf_sub", mk(1, 0, 8'hFF, '0, TYPE_INF, 0, 8'hFF, '0, TYPE_INF), r);
        check("inf_minus_inf", r.r_word, 32'h7FC00000);
        send_single("one_sub_inf", mk(1, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'hFF, '0, TYPE_INF), r);
        check("one_minus_inf", r.r_word, 32'hFF800000);
        send_single("negzero", mk(0, 1, 8'd0, '0, TYPE_ZERO, 1, 8'd0, '0, TYPE_ZERO), r);
        check("negzero_special", 32'(r.r_spec), 32'd1);
        check("negzero_word", r.r_word, 32'h80000000);

        // Four pairs into a stalled output: two fit, then backpressure.
        p0 = mk(0, 0, 8'd127, ONE, TYPE_NORMAL, 0, 8'd127, ONE, TYPE_NORMAL);
        p1 = mk(0, 1, 8'd127, ONE, TYPE_NORMAL, 0, 8'd126, ONE, TYPE_NORMAL);
        p2 = mk(1, 0, 8'd127, ONE, TYPE_NORMAL, 1, 8'd87, ONE, TYPE_NORMAL);
        p3 = mk(0, 0, 8'd1, ONE, TYPE_NORMAL, 0, 8'd0, 26'h0800000, TYPE_DENORM);
        e0 = model(p0); e1 = model(p1); e2 = model(p2); e3 = model(p3);
        bus.out_ready = 1'b0;
        drive(p0); bus.in_valid = 1'b1; #1;
        check("stall_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(p1); #1;
        check("stall_rdy1", 32'(bus.in_ready), 32'd1);
        tick();
        drive(p2); #1;
        check("stall_rdy2", 32'(bus.in_ready), 32'd0);
        check("stall_ov", 32'(bus.out_valid), 32'd1);
        check_res("stall_e0", observe(), e0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_hold_rdy", 32'(bus.in_ready), 32'd0);
            check_res("stall_hold_data", observe(), e0);
        end
        bus.out_ready = 1'b1; #1;
        check("release_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        check_res("release_e1", observe(), e1);
        drive(p3); #1;
        check("release_rdy3", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_res("release_e2", observe(), e2);
        tick();
        check("release_ov3", 32'(bus.out_valid), 32'd1);
        check_res("release_e3", observe(), e3);
        tick();
        check("release_empty", 32'(bus.out_valid), 32'd0);

        // Random valid/ready stalls against the reference model.
        sent = 0; recv = 0; holding = 1'b0; cur = '0;
        for (int cyc = 0; cyc < 6000 && recv < 400; cyc++) begin
            if (!holding) begin
                if (sent < 400 && $urandom_range(0, 3) != 0) begin
                    rand_pair(cur);
                    drive(cur);
                    bus.in_valid = 1'b1;
                    holding = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected", 32'd1, 32'd0);
                end else begin
                    ex = q.pop_front();
                    r  = observe();
                    if (ex.r_spec) begin
                        check("stream_special", 32'(r.r_spec), 32'd1);
                        check("stream_word", r.r_word, ex.r_word);
                    end else begin
                        check_res("stream_data", r, ex);
                    end
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(cur));
                sent++;
                holding = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("stream_count", 32'(recv), 32'd400);

        // Reset with two pairs in flight.
        bus.out_ready = 1'b0;
        drive(p1); bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_res_exp", 32'(bus.res_exp), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("midrst_flushed", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
